// File: rtl/seg7_scan_driver.sv
// seg7_scan_driver: 4-digit multiplexed 7-segment scan transmitter.
// Digit values are captured into a shadow bank on load and copied into the
// active bank only at the frame boundary, so one frame never mixes old and new
// values. Each digit slot is preceded by an all-off gap to suppress ghosting.
// All outputs are registered and computed from the next-state values, so they
// change on the same edge that consumes the terminating tick.
module seg7_scan_driver #(
    parameter int DIV         = 50000,
    parameter int ON_TICKS    = 4,
    parameter int BLANK_TICKS = 1
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        load,
    input  logic [15:0] values,
    input  logic [3:0]  dp_in,
    input  logic [3:0]  blank_mask,
    output logic [6:0]  seg,
    output logic        dp,
    output logic [3:0]  dig,
    output logic        frame_start,
    output logic        pending
);

    localparam int PW   = (DIV > 1) ? $clog2(DIV) : 1;
    localparam int TMAX = (ON_TICKS > BLANK_TICKS) ? ON_TICKS : BLANK_TICKS;
    localparam int TW   = (TMAX > 1) ? $clog2(TMAX) : 1;

    typedef enum logic {
        ST_BLANK = 1'b0,
        ST_SHOW  = 1'b1
    } state_t;

    // Hex nibble to {a,b,c,d,e,f,g}
    function automatic logic [6:0] encode(input logic [3:0] nib);
        logic [6:0] s;
        case (nib)
            4'h0: s = 7'h7E;
            4'h1: s = 7'h30;
            4'h2: s = 7'h6D;
            4'h3: s = 7'h79;
            4'h4: s = 7'h33;
            4'h5: s = 7'h5B;
            4'h6: s = 7'h5F;
            4'h7: s = 7'h70;
            4'h8: s = 7'h7F;
            4'h9: s = 7'h7B;
            4'hA: s = 7'h77;
            4'hB: s = 7'h1F;
            4'hC: s = 7'h4E;
            4'hD: s = 7'h3D;
            4'hE: s = 7'h4F;
            default: s = 7'h47;
        endcase
        return s;
    endfunction

    // Prescaler, scan FSM, buffers and registered outputs
    logic [PW-1:0] presc_q, presc_d;
    state_t        state_q, state_d;
    logic [1:0]    idx_q, idx_d;
    logic [TW-1:0] phase_q, phase_d;

    logic [15:0]   sh_vals_q, sh_vals_d;
    logic [3:0]    sh_dp_q, sh_dp_d;
    logic [3:0]    sh_blank_q, sh_blank_d;
    logic [15:0]   act_vals_q, act_vals_d;
    logic [3:0]    act_dp_q, act_dp_d;
    logic [3:0]    act_blank_q, act_blank_d;
    logic          pending_q, pending_d;

    logic [6:0]    seg_q, seg_d;
    logic          dp_q, dp_d;
    logic [3:0]    dig_q, dig_d;
    logic          frame_start_q, frame_start_d;

    logic          tick;
    logic          phase_done;
    logic          boundary;
    logic [3:0]    cur_nib;

    // Scan tick generator: free-running count 0..DIV-1
    always_comb begin
        tick    = (presc_q == PW'(DIV - 1));
        presc_d = tick ? '0 : presc_q + PW'(1);
    end

    // Scan FSM next state: BLANK gap then SHOW slot, stepping idx on BLANK->SHOW
    always_comb begin
        state_d    = state_q;
        idx_d      = idx_q;
        phase_d    = phase_q;
        boundary   = 1'b0;
        phase_done = (state_q == ST_BLANK) ? (phase_q == TW'(BLANK_TICKS - 1))
                                           : (phase_q == TW'(ON_TICKS - 1));
        if (tick) begin
            if (phase_done) begin
                phase_d = '0;
                if (state_q == ST_BLANK) begin
                    state_d  = ST_SHOW;
                    idx_d    = idx_q + 2'd1;
                    boundary = (idx_q == 2'd3);
                end else begin
                    state_d = ST_BLANK;
                end
            end else begin
                phase_d = phase_q + TW'(1);
            end
        end
    end

    // Double buffer: shadow captures every load, active takes shadow at the frame boundary
    always_comb begin
        sh_vals_d   = sh_vals_q;
        sh_dp_d     = sh_dp_q;
        sh_blank_d  = sh_blank_q;
        act_vals_d  = act_vals_q;
        act_dp_d    = act_dp_q;
        act_blank_d = act_blank_q;
        pending_d   = pending_q;
        if (boundary) begin
            if (pending_q) begin
                act_vals_d  = sh_vals_q;
                act_dp_d    = sh_dp_q;
                act_blank_d = sh_blank_q;
            end
            pending_d = 1'b0;
        end
        // A load on the boundary edge lands in the shadow and keeps pending set
        if (load) begin
            sh_vals_d  = values;
            sh_dp_d    = dp_in;
            sh_blank_d = blank_mask;
            pending_d  = 1'b1;
        end
    end

    // Output decode from next-state so digit 0 of a new frame shows freshly applied values
    always_comb begin
        seg_d         = '0;
        dp_d          = 1'b0;
        dig_d         = '0;
        frame_start_d = boundary;
        cur_nib       = act_vals_d[{idx_d, 2'b00} +: 4];
        if (state_d == ST_SHOW) begin
            dig_d = 4'b0001 << idx_d;
            if (!act_blank_d[idx_d]) begin
                seg_d = encode(cur_nib);
                dp_d  = act_dp_d[idx_d];
            end
        end
    end

    // State register; reset restarts the scan from the gap before digit 0
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            presc_q       <= '0;
            state_q       <= ST_BLANK;
            idx_q         <= 2'd3;
            phase_q       <= '0;
            sh_vals_q     <= '0;
            sh_dp_q       <= '0;
            sh_blank_q    <= '0;
            act_vals_q    <= '0;
            act_dp_q      <= '0;
            act_blank_q   <= '0;
            pending_q     <= 1'b0;
            seg_q         <= '0;
            dp_q          <= 1'b0;
            dig_q         <= '0;
            frame_start_q <= 1'b0;
        end else begin
            presc_q       <= presc_d;
            state_q       <= state_d;
            idx_q         <= idx_d;
            phase_q       <= phase_d;
            sh_vals_q     <= sh_vals_d;
            sh_dp_q       <= sh_dp_d;
            sh_blank_q    <= sh_blank_d;
            act_vals_q    <= act_vals_d;
            act_dp_q      <= act_dp_d;
            act_blank_q   <= act_blank_d;
            pending_q     <= pending_d;
            seg_q         <= seg_d;
            dp_q          <= dp_d;
            dig_q         <= dig_d;
            frame_start_q <= frame_start_d;
        end
    end

    assign seg         = seg_q;
    assign dp          = dp_q;
    assign dig         = dig_q;
    assign frame_start = frame_start_q;
    assign pending     = pending_q;

endmodule

// File: tb/tb_seg7_scan_driver.sv
// Testbench for seg7_scan_driver: expected digit slots are queued by the
// stimulus process and a monitor compares each completed slot as it appears.
module tb_seg7_scan_driver;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        reset = 1'b1;
    logic        load = 1'b0;
    logic [15:0] values = '0;
    logic [3:0]  dp_in = '0;
    logic [3:0]  blank_mask = '0;

    logic [6:0] seg1, seg3;
    logic       dp1, dp3, fs1, fs3, pend1, pend3;
    logic [3:0] dig1, dig3;

    seg7_scan_driver #(.DIV(1), .ON_TICKS(3), .BLANK_TICKS(1)) u_dut1 (
        .clk(clk), .reset(reset), .load(load), .values(values), .dp_in(dp_in),
        .blank_mask(blank_mask), .seg(seg1), .dp(dp1), .dig(dig1),
        .frame_start(fs1), .pending(pend1)
    );

    seg7_scan_driver #(.DIV(3), .ON_TICKS(3), .BLANK_TICKS(1)) u_dut3 (
        .clk(clk), .reset(reset), .load(load), .values(values), .dp_in(dp_in),
        .blank_mask(blank_mask), .seg(seg3), .dp(dp3), .dig(dig3),
        .frame_start(fs3), .pending(pend3)
    );

    // Observed instance select: 0 -> DIV=1 instance, 1 -> DIV=3 instance
    logic       sel = 1'b0;
    logic [6:0] m_seg;
    logic       m_dp, m_fs, m_pend;
    logic [3:0] m_dig;
    assign m_seg  = sel ? seg3  : seg1;
    assign m_dp   = sel ? dp3   : dp1;
    assign m_fs   = sel ? fs3   : fs1;
    assign m_pend = sel ? pend3 : pend1;
    assign m_dig  = sel ? dig3  : dig1;

    typedef struct {
        logic [3:0] dig;
        logic [6:0] seg;
        logic       dp;
        int         len;
        int         gap;
        logic       fs;
    } slot_t;

    slot_t exp_q[$];
    int    vectors = 0;
    int    miscompares = 0;
    int    cur_div = 1;
    bit    mon_en = 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        vectors++;
        if (act !== req) begin
            miscompares++;
            $display("FAIL %s: got %h, required %h", name, act, req);
        end
    endtask

    task automatic push_slot(input logic [3:0] d, input logic [6:0] s, input logic p, input logic f);
        slot_t e;
        e.dig = d;
        e.seg = s;
        e.dp  = p;
        e.len = 3 * cur_div;
        e.gap = 1 * cur_div;
        e.fs  = f;
        exp_q.push_back(e);
    endtask

    task automatic push_frame(input logic [6:0] s0, input logic [6:0] s1,
                              input logic [6:0] s2, input logic [6:0] s3,
                              input logic [3:0] dpm);
        push_slot(4'b0001, s0, dpm[0], 1'b1);
        push_slot(4'b0010, s1, dpm[1], 1'b0);
        push_slot(4'b0100, s2, dpm[2], 1'b0);
        push_slot(4'b1000, s3, dpm[3], 1'b0);
    endtask

    task automatic wait_fs(input string name);
        int n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!m_fs && n < 200);
        if (!m_fs) begin
            miscompares++;
            $display("FAIL %s: frame_start not seen within %0d cycles", name, n);
        end
    endtask

    task automatic do_load(input logic [15:0] v, input logic [3:0] d, input logic [3:0] b);
        @(posedge clk);
        #2;
        load       = 1'b1;
        values     = v;
        dp_in      = d;
        blank_mask = b;
        @(posedge clk);
        #2;
        load = 1'b0;
    endtask

    task automatic drain(input string name);
        int n = 0;
        while (exp_q.size() != 0 && n < 400) begin
            @(posedge clk);
            n++;
        end
        if (exp_q.size() != 0) begin
            miscompares++;
            $display("FAIL %s: %0d expected slots never seen", name, exp_q.size());
        end
        mon_en = 1'b0;
    endtask

    // Monitor: gathers each lit slot, pops the matching expectation when it ends
    initial begin
        slot_t cur;
        slot_t e;
        bit    in_slot = 1'b0;
        bit    steady = 1'b1;
        int    gap_cnt = 0;
        int    slot_no = 0;
        cur = '{dig: 4'b0, seg: 7'b0, dp: 1'b0, len: 0, gap: 0, fs: 1'b0};
        forever begin
            @(negedge clk);
            if (reset || !mon_en) begin
                in_slot = 1'b0;
                gap_cnt = 0;
            end else begin
                if (m_dig != 4'b0 && !$onehot(m_dig)) begin
                    miscompares++;
                    $display("FAIL dig_onehot: got dig=%b, required one-hot or zero", m_dig);
                end
                if (m_dig == 4'b0 && (m_seg != 7'b0 || m_dp)) begin
                    miscompares++;
                    $display("FAIL dark_bus: got seg=%h dp=%b with dig=0, required 0", m_seg, m_dp);
                end
                if (m_fs && (m_dig == 4'b0 || in_slot)) begin
                    miscompares++;
                    $display("FAIL fs_position: got frame_start=1 outside a slot start, required 0");
                end
                if (m_dig != 4'b0) begin
                    if (!in_slot) begin
                        in_slot = 1'b1;
                        steady  = 1'b1;
                        cur.dig = m_dig;
                        cur.seg = m_seg;
                        cur.dp  = m_dp;
                        cur.fs  = m_fs;
                        cur.len = 1;
                        cur.gap = gap_cnt;
                    end else begin
                        cur.len++;
                        if (m_dig != cur.dig || m_seg != cur.seg || m_dp != cur.dp)
                            steady = 1'b0;
                    end
                end else if (in_slot) begin
                    in_slot = 1'b0;
                    gap_cnt = 1;
                    vectors++;
                    if (exp_q.size() == 0) begin
                        miscompares++;
                        $display("FAIL slot%0d: got unexpected slot dig=%b seg=%h, required none",
                                 slot_no, cur.dig, cur.seg);
                    end else begin
                        e = exp_q.pop_front();
                        if (cur.dig !== e.dig || cur.seg !== e.seg || cur.dp !== e.dp ||
                            cur.len != e.len || cur.gap != e.gap || cur.fs !== e.fs || !steady) begin
                            miscompares++;
                            $display("FAIL slot%0d: got dig=%b seg=%h dp=%b len=%0d gap=%0d fs=%b steady=%b, required dig=%b seg=%h dp=%b len=%0d gap=%0d fs=%b steady=1",
                                     slot_no, cur.dig, cur.seg, cur.dp, cur.len, cur.gap, cur.fs, steady,
                                     e.dig, e.seg, e.dp, e.len, e.gap, e.fs);
                        end
                    end
                    slot_no++;
                end else begin
                    gap_cnt++;
                end
            end
        end
    end

    // Stimulus
    initial begin
        int n;

        // Reset state, DIV=1 instance
        mon_en = 1'b1;
        repeat (3) @(posedge clk);
        #2;
        chk("rst_dig", 32'(m_dig), 32'h0);
        chk("rst_seg", 32'(m_seg), 32'h0);
        chk("rst_dp", 32'(m_dp), 32'h0);
        chk("rst_fs", 32'(m_fs), 32'h0);
        chk("rst_pending", 32'(m_pend), 32'h0);

        // Frame 1: active values all zero -> "0" on every digit
        push_frame(7'h7E, 7'h7E, 7'h7E, 7'h7E, 4'b0000);
        reset = 1'b0;
        wait_fs("fs_f1");

        // Mid-frame load: current frame unchanged, next frame shows 1,2,3,4
        repeat (4) @(posedge clk);
        do_load(16'h4321, 4'b0010, 4'b0000);
        chk("pending_after_load", 32'(m_pend), 32'h1);
        push_frame(7'h30, 7'h6D, 7'h79, 7'h33, 4'b0010);
        wait_fs("fs_f2");
        chk("pending_after_boundary", 32'(m_pend), 32'h0);

        // Two loads in one frame: only the last one is applied
        do_load(16'h1111, 4'b0000, 4'b0000);
        repeat (3) @(posedge clk);
        do_load(16'hFFFF, 4'b0000, 4'b0000);
        chk("pending_two_loads", 32'(m_pend), 32'h1);
        push_frame(7'h47, 7'h47, 7'h47, 7'h47, 4'b0000);
        wait_fs("fs_f3");

        // Blanked digit 2 keeps its slot with segments dark
        repeat (2) @(posedge clk);
        do_load(16'h8888, 4'b0000, 4'b0100);
        push_frame(7'h7F, 7'h7F, 7'h00, 7'h7F, 4'b0000);
        wait_fs("fs_f4");

        // Reset while digit 2 slot is lit
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (m_dig != 4'b0100 && n < 40);
        @(posedge clk);
        #2;
        chk("dig_before_reset", 32'(m_dig), 32'h4);
        reset = 1'b1;
        #1;
        chk("async_rst_dig", 32'(m_dig), 32'h0);
        chk("async_rst_seg", 32'(m_seg), 32'h0);
        chk("async_rst_dp", 32'(m_dp), 32'h0);
        chk("async_rst_fs", 32'(m_fs), 32'h0);
        exp_q.delete();
        repeat (2) @(posedge clk);
        #2;
        chk("rst_pending_cleared", 32'(m_pend), 32'h0);
        push_frame(7'h7E, 7'h7E, 7'h7E, 7'h7E, 4'b0000);
        reset = 1'b0;
        wait_fs("fs_after_reset");
        drain("drain_div1");

        // DIV=3 instance: slots of 9 cycles, gaps of 3 cycles, 48-cycle frames
        @(posedge clk);
        #2;
        reset   = 1'b1;
        sel     = 1'b1;
        cur_div = 3;
        exp_q.delete();
        repeat (2) @(posedge clk);
        #2;
        mon_en = 1'b1;
        push_frame(7'h7E, 7'h7E, 7'h7E, 7'h7E, 4'b0000);
        reset = 1'b0;
        wait_fs("fs3_f1");
        repeat (10) @(posedge clk);
        do_load(16'hBEAD, 4'b1001, 4'b0000);
        chk("pending3_after_load", 32'(m_pend), 32'h1);
        push_frame(7'h3D, 7'h77, 7'h4F, 7'h1F, 4'b1001);
        wait_fs("fs3_f2");
        chk("pending3_after_boundary", 32'(m_pend), 32'h0);
        repeat (10) @(posedge clk);
        do_load(16'h9C75, 4'b1110, 4'b1000);
        push_frame(7'h5B, 7'h70, 7'h4E, 7'h00, 4'b0110);
        wait_fs("fs3_f3");
        drain("drain_div3");

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    // Global time bound
    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete, required completion");
        $fatal(1, "watchdog expired");
    end

endmodule

// File: doc/seg7_scan_driver.md
Name: seg7_scan_driver

Overview:
- Segment-side transmitter for the 4-digit multiplexed 7-segment display bus.
- Latches four 4-bit digit values and time-multiplexes them onto a shared segment bus with matching one-hot digit enables.
- Inserts a blanking gap between digits to suppress ghosting.
- Double-buffers loads so new values apply only at frame boundaries, so a frame never mixes old and new values.

Parameters:
- DIV, 50000, clk cycles per scan tick (>=1)
- ON_TICKS, 4, ticks each digit is lit (>=1)
- BLANK_TICKS, 1, ticks of all-off gap before each digit (>=1)

Ports:
- clk  input  1  system clock
- reset  input  1  asynchronous, active-high reset
- load  input  1  capture strobe for values/dp_in/blank_mask
- values  input  16  digit k = values[4k+3:4k], hex nibble
- dp_in  input  4  decimal point per digit
- blank_mask  input  4  1 = digit k is dark during its slot
- seg  output  7  segments {a,b,c,d,e,f,g} = seg[6:0], active-high
- dp  output  1  decimal point, active-high
- dig  output  4  one-hot digit enable, active-high; dig[k] drives digit k
- frame_start  output  1  one-cycle pulse when digit 0 slot begins
- pending  output  1  shadow holds values not yet applied

Behaviour:
- Asynchronous reset state:
  - seg=0, dp=0, dig=0, frame_start=0, pending=0
  - shadow and active registers = 0
  - prescaler=0, phase count=0
  - state=BLANK, idx=3
- Prescaler: counts 0..DIV-1 and wraps. tick=1 on the cycle the count equals DIV-1. With DIV=1, tick is high every cycle.
- FSM (advances on tick only):
  - BLANK: dig=0, seg=0, dp=0. After BLANK_TICKS ticks: idx <= idx+1 (mod 4), state <= SHOW.
  - SHOW: dig = one-hot(idx); seg = encode(active value[idx]); dp = active dp[idx]. After ON_TICKS ticks: state <= BLANK.
- Register timing: all outputs are registered. They change on the clk edge that consumes the terminating tick.
- Frame boundary = the BLANK->SHOW transition where idx wraps 3->0. On that same edge:
  - if pending=1: active <= shadow, pending <= 0
  - frame_start = 1 for exactly that one cycle
  - seg/dp for digit 0 use the newly applied values
- load:
  - On any cycle with load=1: shadow <= {values, dp_in, blank_mask}; pending <= 1.
  - Consecutive loads overwrite the shadow; only the last one before the boundary is applied.
  - load on the boundary edge itself: the old shadow is applied to active, the new data is captured into shadow, and pending stays 1.
- Blanked digit (blank_mask[k]=1 in active): the slot timing is unchanged. dig[k]=1, seg=0, dp=0.
- Encoding (abcdefg):
  - 0=7E, 1=30, 2=6D, 3=79, 4=33, 5=5B, 6=5F, 7=70
  - 8=7F, 9=7B, A=77, b=1F, C=4E, d=3D, E=4F, F=47
- Invariants:
  - dig is never multi-hot.
  - seg/dp are nonzero only when dig is nonzero.
  - A digit slot lasts ON_TICKS*DIV cycles; a frame lasts 4*(ON_TICKS+BLANK_TICKS)*DIV cycles.
- Reset asserted mid-slot: all outputs clear immediately (asynchronously). After release the sequence restarts from BLANK with idx=3, so digit 0 is first lit BLANK_TICKS*DIV cycles later, with active values = 0.

Test Plan:
- Reset release, DIV=1, ON=3, BLANK=1, no load:
  - dig=0 for 1 cycle
  - then dig=0001 with seg=7E for 3 cycles, alongside a frame_start pulse
  - then 1 blank cycle, dig=0010, and so on
  - frame_start repeats every 16 cycles
- load values=0x4321, dp_in=0010, blank_mask=0 mid-frame:
  - pending=1 and the current frame is unchanged
  - at the next frame_start: digits show 30,6D,79,33, with dp=1 only while dig=0010
  - pending=0 after the boundary
- Two loads in one frame (0x1111 then 0xFFFF): the next frame shows 47 on all digits; 0x1111 is never displayed.
- blank_mask=0100, values=0x8888:
  - dig=0100 slot keeps its 3-cycle length with seg=0
  - the other digits show 7F
- DIV=3: tick every 3rd cycle. Each digit is lit 9 cycles, each gap is 3 cycles, and the frame is 48 cycles.
- Assert reset while dig=0100: outputs are 0 in the same cycle. After release, the first lit digit is dig=0001 with seg=7E.
